seg_reader: RTL

SEG_READER -- requirements
Module: seg_reader

---
 rtl/seg_reader.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/seg_reader.sv
// seg_reader: recovers a four-digit frame from a multiplexed, active-low
// seven-segment display bus by sampling it, debouncing each digit and
// assembling the digits in order.
//
// Ports:
//   clk    in   1   rising-edge clock
//   rst    in   1   synchronous active-high reset
//   seg    in   7   active-low segments {g,f,e,d,c,b,a}
//   an     in   4   active-low digit enables (one low = digit index)
//   value  out 16   last published frame, digit0 in [15:12] .. digit3 in [3:0]
//   valid  out  1   one-cycle pulse when value/err are updated
//   err    out  1   last published frame held an unrecognised pattern
//   busy   out  1   a frame is partially captured
module seg_reader #(
    parameter int unsigned STABLE_CYC = 4,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  seg,
    input  logic [3:0]  an,
    output logic [15:0] value,
    output logic        valid,
    output logic        err,
    output logic        busy
);

    localparam int unsigned RUN_W = 8;
    localparam int unsigned TMO_W = 16;
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(STABLE_CYC);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    // State code equals the index of the digit that state expects next.
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CAP1 = 2'd1;
    localparam logic [1:0] S_CAP2 = 2'd2;
    localparam logic [1:0] S_CAP3 = 2'd3;

    logic [6:0]       r_seg, r_prev_seg;
    logic [3:0]       r_an, r_prev_an;
    logic [RUN_W-1:0] r_run;
    logic [TMO_W-1:0] r_tmo;
    logic [1:0]       r_state;
    logic [3:0]       r_d0, r_d1, r_d2;
    logic             r_err_acc;
    logic [15:0]      r_value;
    logic             r_valid;
    logic             r_err;

    logic             w_smp_ok;
    logic [1:0]       w_idx;
    logic             w_same;
    logic [RUN_W-1:0] w_run_nxt;
    logic             w_accept;
    logic [3:0]       w_code;
    logic             w_bad;
    logic [1:0]       w_state_nxt;
    logic             w_load0;
    logic             w_keep;
    logic             w_publish;

    // Pattern decode: returns {unrecognised, code}.
    function automatic logic [4:0] f_decode(input logic [6:0] s);
        case (s)
            7'b1000000: f_decode = 5'h00;
            7'b1111001: f_decode = 5'h01;
            7'b0100100: f_decode = 5'h02;
            7'b0110000: f_decode = 5'h03;
            7'b0011001: f_decode = 5'h04;
            7'b0010010: f_decode = 5'h05;
            7'b0000010: f_decode = 5'h06;
            7'b1111000: f_decode = 5'h07;
            7'b0000000: f_decode = 5'h08;
            7'b0010000: f_decode = 5'h09;
            default:    f_decode = 5'h1F;
        endcase
    endfunction

    // Sample qualification and digit index from the registered enables.
    always_comb begin
        w_smp_ok = 1'b1;
        w_idx    = 2'd0;
        case (r_an)
            4'b1110: w_idx = 2'd0;
            4'b1101: w_idx = 2'd1;
            4'b1011: w_idx = 2'd2;
            4'b0111: w_idx = 2'd3;
            default: w_smp_ok = 1'b0;
        endcase
    end

    assign w_same = (r_seg == r_prev_seg) && (r_an == r_prev_an);
    assign {w_bad, w_code} = f_decode(r_seg);

    // Run length of the current sample, saturating at STABLE_CYC.
    always_comb begin
        w_run_nxt = '0;
        if (w_smp_ok && w_same)
            w_run_nxt = (r_run == RUN_MAX) ? r_run : r_run + RUN_W'(1);
        else if (w_smp_ok)
            w_run_nxt = RUN_W'(1);
    end

    // Accept only on the sample that first reaches the threshold; a saturated run stays quiet.
    assign w_accept = (w_run_nxt == RUN_MAX) && !(w_same && (r_run == RUN_MAX));

    // Frame sequencing; acceptance takes precedence over timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_load0     = 1'b0;
        w_keep      = 1'b0;
        w_publish   = 1'b0;
        if (w_accept) begin
            if (w_idx == 2'd0) begin
                w_state_nxt = S_CAP1;
                w_load0     = 1'b1;
            end else if ((r_state != S_IDLE) && (w_idx == r_state)) begin
                if (r_state == S_CAP3) begin
                    w_state_nxt = S_IDLE;
                    w_publish   = 1'b1;
                end else begin
                    w_state_nxt = r_state + 2'd1;
                    w_keep      = 1'b1;
                end
            end else if (r_state != S_IDLE) begin
                w_state_nxt = S_IDLE;
            end
        end else if ((r_state != S_IDLE) && (r_tmo == TMO_LAST)) begin
            w_state_nxt = S_IDLE;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Input sampling, run and timeout counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg      <= 7'b1111111;
            r_an       <= 4'b1111;
            r_prev_seg <= 7'b1111111;
            r_prev_an  <= 4'b1111;
            r_run      <= '0;
            r_tmo      <= '0;
        end else begin
            r_seg      <= seg;
            r_an       <= an;
            r_prev_seg <= r_seg;
            r_prev_an  <= r_an;
            r_run      <= w_run_nxt;
            if (w_accept || (w_state_nxt == S_IDLE)) r_tmo <= '0;
            else                                     r_tmo <= r_tmo + TMO_W'(1);
        end
    end

    // Digit capture, error accumulation and frame publication.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_d0      <= '0;
            r_d1      <= '0;
            r_d2      <= '0;
            r_err_acc <= 1'b0;
            r_value   <= '0;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_valid <= w_publish;
            if (w_load0) begin
                r_d0      <= w_code;
                r_err_acc <= w_bad;
            end else if (w_keep) begin
                if (w_idx == 2'd1) r_d1 <= w_code;
                else               r_d2 <= w_code;
                r_err_acc <= r_err_acc | w_bad;
            end
            if (w_publish) begin
                r_value <= {r_d0, r_d1, r_d2, w_code};
                r_err   <= r_err_acc | w_bad;
            end
        end
    end

    assign value = r_value;
    assign valid = r_valid;
    assign err   = r_err;
    assign busy  = (r_state != S_IDLE);

endmodule
